mem_port_arbiter: RTL and testbench

Shares the single unified memory port of the pipeline model between instruction fetch and the load/store path in the memory stage. Each access is a registered request/acknowledge transaction with variable memory latency. The block stalls the requesting stages until their access completes. Data accesses have priority over fetch, with a bounded-streak rule so fetch is never starved. It sits between the fetch/memory stages and the external memory model; the decoder's memtoreg/memwrite drive the data request.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; data wins unless fetch has waited MAX_DSTREAK grants.
// Latency: 2 + memory wait cycles (min 3 cycles per access); requesters see stall_* until their valid pulse.
// Optional ack timeout with sticky err is compiled in with MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic [DW-1:0]     if_rdata,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    input  logic [DW/8-1:0]   d_be,
    output logic [DW-1:0]     d_rdata,
    output logic              d_valid,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_be,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t           state_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [DW-1:0]    mem_wdata_q;
    logic [DW/8-1:0]  mem_be_q;
    logic [DW-1:0]    if_rdata_q;
    logic [DW-1:0]    d_rdata_q;
    logic             if_valid_q;
    logic             d_valid_q;
    logic [SW-1:0]    streak_q;
    logic             busy;
    logic             timeout_w;

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef MEMARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q;
    logic          err_q;

    // Fires on the TIMEOUT-th busy cycle; an ack in that same cycle still wins.
    assign timeout_w = busy && !mem_ack && (wait_q == TW'(TIMEOUT - 1));
    assign err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= busy ? wait_q + 1'b1 : '0;
            if (timeout_w)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_w = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            streak_q    <= '0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!if_req)
                        streak_q <= '0;
                    if (d_req && !(if_req && streak_q == SW'(MAX_DSTREAK))) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_be_q    <= d_be;
                        // Below MAX here, since at MAX a waiting fetch takes the grant.
                        if (if_req)
                            streak_q <= streak_q + 1'b1;
                    end else if (if_req) begin
                        // Fetch is a plain full-word read.
                        state_q     <= BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                        mem_be_q    <= '1;
                        streak_q    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack || timeout_w) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (state_q == BUSY_I) begin
                            if_rdata_q <= mem_ack ? mem_rdata : '0;
                            if_valid_q <= 1'b1;
                        end else begin
                            if (!mem_we_q || !mem_ack)
                                d_rdata_q <= mem_ack ? mem_rdata : '0;
                            d_valid_q <= 1'b1;
                        end
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_valid   = d_valid_q;
    assign stall_f   = if_req & ~if_valid_q;
    assign stall_m   = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-arithmetic transaction model.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        if_valid, d_valid, stall_f, stall_m, mem_req, mem_we, err;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DSTREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .stall_f(stall_f), .stall_m(stall_m),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: an access granted at edge g and completed at edge c occupies the port until edge c+2.
    bit          m_busy, m_who_d, m_req, m_we, m_ifv, m_dv, m_err;
    int          m_gnt, m_free, m_streak;
    logic [31:0] m_addr, m_wdata, m_ifr, m_dr;
    logic [3:0]  m_be;

    int          mr_cnt = -1;
    int          mem_wait = 0;
    bit          mem_never = 0, rnd_mem = 0, spur_en = 0;
    logic [31:0] mem_rd_fix = '0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_who_d = 0; m_req = 0; m_we = 0; m_ifv = 0; m_dv = 0; m_err = 0;
        m_gnt = 0; m_free = 0; m_streak = 0;
        m_addr = '0; m_wdata = '0; m_ifr = '0; m_dr = '0; m_be = '0;
    endtask

    task automatic model_edge();
        bit          to;
        logic [31:0] v;
        if (reset) begin
            model_reset();
            return;
        end
        m_ifv = 0;
        m_dv  = 0;
        to    = 0;
        if (m_busy) begin
`ifdef MEMARB_TIMEOUT_EN
            to = !mem_ack && (cyc - m_gnt == TMO);
`endif
            if (mem_ack || to) begin
                v      = mem_ack ? mem_rdata : 32'h0;
                m_busy = 0;
                m_req  = 0;
                m_free = cyc + 2;
                if (!m_who_d) begin
                    m_ifr = v;
                    m_ifv = 1;
                end else begin
                    if (!m_we || to) m_dr = v;
                    m_dv = 1;
                end
                if (to) m_err = 1;
            end
        end else if (cyc >= m_free) begin
            if (!if_req) m_streak = 0;
            if (d_req && !(if_req && m_streak == MAXS)) begin
                m_busy = 1; m_who_d = 1; m_gnt = cyc; m_req = 1;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
                if (if_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            end else if (if_req) begin
                m_busy = 1; m_who_d = 0; m_gnt = cyc; m_req = 1;
                m_we = 0; m_addr = if_addr; m_wdata = '0; m_be = 4'hF;
                m_streak = 0;
            end
        end
    endtask

    task automatic compare();
        chk1("mem_req", mem_req, m_req);
        chk1("mem_we", mem_we, m_we);
        chk32("mem_addr", mem_addr, m_addr);
        chk32("mem_wdata", mem_wdata, m_wdata);
        chk32("mem_be", 32'(mem_be), 32'(m_be));
        chk32("if_rdata", if_rdata, m_ifr);
        chk32("d_rdata", d_rdata, m_dr);
        chk1("if_valid", if_valid, m_ifv);
        chk1("d_valid", d_valid, m_dv);
        chk1("stall_f", stall_f, if_req & ~m_ifv);
        chk1("stall_m", stall_m, d_req & ~m_dv);
        chk1("err", err, m_err);
    endtask

    task automatic drive_mem();
        if (mem_req) begin
            if (mr_cnt < 0) mr_cnt = rnd_mem ? int'($urandom_range(0, 4)) : mem_wait;
            if (mr_cnt == 0 && !mem_never) begin
                mem_ack   = 1'b1;
                mem_rdata = rnd_mem ? $urandom : mem_rd_fix;
                mr_cnt    = -1;
            end else begin
                mem_ack = 1'b0;
                if (mr_cnt > 0) mr_cnt--;
            end
        end else begin
            mr_cnt    = -1;
            mem_ack   = spur_en && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare();
        drive_mem();
    endtask

    task automatic rnd_drive(input bit allow_new);
        if (if_req) begin
            if (if_valid) begin
                if (allow_new && $urandom_range(0, 1) == 1) if_addr = $urandom;
                else if_req = 1'b0;
            end
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
        end
        if (d_req) begin
            if (d_valid) begin
                if (allow_new && $urandom_range(0, 1) == 1) begin
                    d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
                end else d_req = 1'b0;
            end
        end else if (allow_new && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
        end
    endtask

    task automatic wait_valid(input bit want_d, input string nm);
        int n;
        n = 0;
        while (n < 50 && !(want_d ? d_valid : if_valid)) begin
            step();
            n++;
        end
        chk1(nm, want_d ? d_valid : if_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got no finish expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nd, nb;
        bit          prev, seen;
        string       got;
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
        d_wdata = 0; d_be = 0; mem_ack = 0; mem_rdata = 0;
        model_reset();
        step(); step();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk1("rst_err", err, 1'b0);
        @(negedge clk); reset = 1'b0;
        step();

        // Lone fetch with immediate ack.
        mem_wait = 0; mem_rd_fix = 32'h00500093;
        if_req = 1'b1; if_addr = 32'h100;
        #1 chk1("lf_stall_pre", stall_f, 1'b1);
        step();
        chk1("lf_mem_req", mem_req, 1'b1);
        chk32("lf_mem_addr", mem_addr, 32'h100);
        chk1("lf_stall_busy", stall_f, 1'b1);
        step();
        chk1("lf_if_valid", if_valid, 1'b1);
        chk32("lf_if_rdata", if_rdata, 32'h00500093);
        chk1("lf_stall_valid", stall_f, 1'b0);
        chk1("lf_mem_req_resp", mem_req, 1'b0);
        if_req = 1'b0;
        step();
        chk1("lf_if_valid_end", if_valid, 1'b0);

        // Load establishes d_rdata, then a slow store must leave it alone.
        d_req = 1; d_we = 0; d_addr = 32'h3000; d_wdata = 0; d_be = 4'hF; mem_rd_fix = 32'h12345678;
        step(); step();
        chk32("ld_d_rdata", d_rdata, 32'h12345678);
        d_req = 0;
        step();
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF;
        mem_wait = 3; mem_rd_fix = 32'hCAFEF00D;
        step();
        for (int i = 0; i < 4; i++) begin
            chk1("st_mem_req", mem_req, 1'b1);
            chk1("st_mem_we", mem_we, 1'b1);
            chk32("st_mem_addr", mem_addr, 32'h2000);
            chk32("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk32("st_mem_be", 32'(mem_be), 32'hF);
            chk1("st_no_valid", d_valid, 1'b0);
            if (i < 3) step();
        end
        step();
        chk1("st_d_valid", d_valid, 1'b1);
        chk32("st_d_rdata_kept", d_rdata, 32'h12345678);
        d_req = 0;
        step();
        chk1("st_d_valid_once", d_valid, 1'b0);

        // Both arrive together: data first, fetch in the IDLE cycle after data's RESP.
        mem_wait = 0; mem_rd_fix = 32'h00000AAA;
        d_req = 1; d_we = 0; d_addr = 32'h4000; if_req = 1; if_addr = 32'h180;
        step();
        chk32("both_first_addr", mem_addr, 32'h4000);
        step();
        chk1("both_d_valid", d_valid, 1'b1);
        chk1("both_stall_f", stall_f, 1'b1);
        d_req = 0;
        step();
        chk1("both_resp_idle", mem_req, 1'b0);
        step();
        chk1("both_f_grant", mem_req, 1'b1);
        chk32("both_f_addr", mem_addr, 32'h180);
        step();
        chk1("both_if_valid", if_valid, 1'b1);
        if_req = 0;
        step();

        // Build a data streak of 3, then reset in the middle of the third BUSY_D.
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h2000;
        nd = 0; prev = mem_req;
        for (int i = 0; i < 40 && nd < 3; i++) begin
            step();
            if (mem_req && !prev) nd++;
            prev = mem_req;
        end
        chk32("rst_mid_grants", 32'(nd), 32'd3);
        chk32("rst_mid_addr", mem_addr, 32'h2000);
        mem_ack = 0; mr_cnt = -1;
        #2 reset = 1'b1;
        #1;
        chk1("rst_mid_mem_req", mem_req, 1'b0);
        chk1("rst_mid_d_valid", d_valid, 1'b0);
        chk1("rst_mid_err", err, 1'b0);
        chk32("rst_mid_addr0", mem_addr, 32'h0);
        chk32("rst_mid_d_rdata", d_rdata, 32'h0);
        step();
        reset = 1'b0;

        // Streak restarts from 0 after reset: four data grants, then fetch.
        got = ""; prev = 0;
        for (int i = 0; i < 80 && got.len() < 10; i++) begin
            step();
            if (mem_req && !prev) got = {got, (mem_addr == 32'h2000) ? "D" : "I"};
            prev = mem_req;
        end
        tests++;
        if (got != "DDDDIDDDDI") begin
            fails++;
            $display("FAIL grant_order got %s expected DDDDIDDDDI", got);
        end
        wait_valid(0, "ord_if_done");
        if_req = 0;
        wait_valid(1, "ord_d_done");
        d_req = 0;
        step(); step();

        // Randomized traffic with variable latency and stray acks.
        rnd_mem = 1; spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            rnd_drive(1'b1);
        end
        for (int i = 0; i < 100 && (if_req || d_req); i++) begin
            step();
            rnd_drive(1'b0);
        end
        chk1("drain_if", if_req, 1'b0);
        chk1("drain_d", d_req, 1'b0);
        rnd_mem = 0; spur_en = 0;
        step(); step();

        // Load that is never acknowledged.
        mem_never = 1;
        d_req = 1; d_we = 0; d_addr = 32'h5000;
        step();
`ifdef MEMARB_TIMEOUT_EN
        nb = 0;
        for (int i = 0; i < 400 && !d_valid; i++) begin
            if (mem_req) nb++;
            step();
        end
        chk32("to_busy_cycles", 32'(nb), 32'd255);
        chk1("to_d_valid", d_valid, 1'b1);
        chk32("to_d_rdata", d_rdata, 32'h0);
        chk1("to_err", err, 1'b1);
        d_req = 0;
        repeat (5) step();
        chk1("to_err_sticky", err, 1'b1);
`else
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (d_valid) seen = 1;
        end
        chk1("noto_mem_req", mem_req, 1'b1);
        chk1("noto_err", err, 1'b0);
        chk1("noto_no_valid", seen, 1'b0);
        d_req = 0;
`endif
        mem_never = 0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk1("end_err_clear", err, 1'b0);
        chk1("end_mem_req", mem_req, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
